// File: rtl/axis_bit_transpose.sv
// AXI-stream bit-matrix transposer: collects NUM rows of W bits, then emits W
// columns of NUM bits (out_data[k] = row k bit j). All outputs registered.

module axis_bit_transpose_row #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wr,
    input  logic [W-1:0] din,
    output logic [W-1:0] nxt
);
    logic [W-1:0] q;

    always_comb begin
        nxt = q;
        if (clr)
            nxt = '0;
        else if (wr)
            nxt = din;
    end

    always_ff @(posedge clock) begin
        if (!rst_n)
            q <= '0;
        else
            q <= nxt;
    end
endmodule

module axis_bit_transpose #(
    parameter int NUM = 8,
    parameter int W   = 6
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [NUM-1:0] out_data,
    output logic           out_valid,
    output logic           out_last,
    input  logic           out_ready,
    output logic           err_short
);
    localparam int RW = $clog2(NUM);
    localparam int CW = $clog2(W);
    localparam logic [RW-1:0] ROW_MAX = RW'(NUM - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [RW-1:0]           row, row_nxt;
    logic [CW-1:0]           col, col_nxt;
    logic                    in_fire, out_fire, blk_end, col_end;
    logic [NUM-1:0]          wr;
    logic [NUM-1:0][W-1:0]   rows_nxt;
    logic                    in_ready_nxt, out_valid_nxt, out_last_nxt, err_short_nxt;
    logic [NUM-1:0]          out_data_nxt;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign blk_end  = in_fire & (in_last | (row == ROW_MAX));
    assign col_end  = out_fire & (col == COL_MAX);

    // Storage is wiped on the DRAIN->FILL edge so short blocks read zeros above in_last.
    for (genvar k = 0; k < NUM; k++) begin : g_row
        assign wr[k] = in_fire && (row == RW'(k));
        axis_bit_transpose_row #(.W(W)) u_row (
            .clock (clock),
            .rst_n (rst_n),
            .clr   (col_end),
            .wr    (wr[k]),
            .din   (in_data),
            .nxt   (rows_nxt[k])
        );
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state     <= FILL;
            row       <= '0;
            col       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err_short <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            col       <= col_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            err_short <= err_short_nxt;
            out_data  <= out_data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        case (state)
            FILL: begin
                if (in_fire)
                    row_nxt = blk_end ? '0 : row + RW'(1);
                if (blk_end)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_fire)
                    col_nxt = col_end ? '0 : col + CW'(1);
                if (col_end) begin
                    state_nxt = FILL;
                    row_nxt   = '0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Outputs are computed from next-state values so column 0 appears one cycle after the last row.
    always_comb begin
        in_ready_nxt  = (state_nxt == FILL);
        out_valid_nxt = (state_nxt == DRAIN);
        out_last_nxt  = (state_nxt == DRAIN) && (col_nxt == COL_MAX);
        err_short_nxt = (state == FILL) && in_fire && in_last && (row != ROW_MAX);
        out_data_nxt  = '0;
        if (state_nxt == DRAIN) begin
            for (int k = 0; k < NUM; k++)
                out_data_nxt[k] = rows_nxt[k][col_nxt];
        end
    end
endmodule

// File: tb/tb_axis_bit_transpose.sv
// Bench for axis_bit_transpose: directed vector table, reset corner sequences,
// and randomized blocks checked against a row/column reference model.

module tb_axis_bit_transpose;
    localparam int NUM = 8;
    localparam int W   = 6;

    typedef logic [NUM-1:0][W-1:0] rows_t;
    typedef logic [W-1:0][NUM-1:0] cols_t;
    typedef struct packed {
        rows_t      rows;
        cols_t      cols;
        logic [7:0] nrows;
        logic [1:0] bp;
        logic       gap;
        logic       lof;
        logic       err;
    } vec_t;

    logic           clock = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready, out_valid, out_last, err_short;
    logic [NUM-1:0] out_data;

    int errors = 0;
    int checks = 0;
    logic [NUM-1:0] got_q[$];
    int nerr_g, ir_low_g, lat_g;
    logic ir_first_g;
    vec_t tbl[5];

    always #5 clock = ~clock;

    axis_bit_transpose #(.NUM(NUM), .W(W)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_short (err_short)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic cols_t model(input rows_t rows, input int n);
        cols_t c;
        for (int j = 0; j < W; j++)
            for (int k = 0; k < NUM; k++)
                c[j][k] = (k < n) ? rows[k][j] : 1'b0;
        return c;
    endfunction

    // bp: 0 always ready, 1 pattern 1,0,0 repeating, 2 random. gap: random in_valid holes.
    task automatic run_block(input rows_t rows, input int nrows, input int bp, input int gap,
                             input int lof, input int stop_cols);
        int ri, c, last_in_c, first_ov, bpi;
        logic [NUM-1:0] prev_d;
        logic prev_l, prev_stall;
        ri = 0; c = 0; last_in_c = -100; first_ov = -1; bpi = 0;
        prev_d = '0; prev_l = 1'b0; prev_stall = 1'b0;
        got_q.delete(); nerr_g = 0; ir_low_g = 0; ir_first_g = 1'b0;
        while (got_q.size() < stop_cols && c < 2000) begin
            @(negedge clock);
            c++;
            if (c == 1) ir_first_g = in_ready;
            if (err_short) nerr_g++;
            if (!in_ready) ir_low_g++;
            if (out_valid && first_ov < 0) first_ov = c;
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_d);
                chk("hold_last", out_last, prev_l);
            end
            if (ri < nrows) begin
                in_valid = (gap == 0) || ($urandom_range(0, 2) != 0);
                in_data  = rows[ri];
                in_last  = (ri == nrows - 1) && (nrows < NUM || lof != 0);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = W'($urandom);
            end
            out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? (bpi % 3 == 0) : 1'($urandom_range(0, 1));
            bpi++;
            if (in_valid && in_ready) begin
                ri++;
                last_in_c = c;
            end
            if (out_valid && out_ready) begin
                chk("out_last", out_last, got_q.size() == W - 1);
                got_q.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
        end
        if (c >= 2000) chk("timeout", 1, 0);
        lat_g = first_ov - last_in_c;
    endtask

    task automatic check_block(input string nm, input cols_t exp, input int exp_err, input int bp);
        chk({nm, "_ncols"}, got_q.size(), W);
        for (int j = 0; j < W && j < got_q.size(); j++)
            chk($sformatf("%s_col%0d", nm, j), got_q[j], exp[j]);
        chk({nm, "_err_short"}, nerr_g, exp_err);
        chk({nm, "_latency"}, lat_g, 1);
        chk({nm, "_ready_first"}, ir_first_g, 1'b1);
        if (bp == 0) chk({nm, "_ready_low"}, ir_low_g, W);
    endtask

    initial begin
        rows_t rr;
        int n;
        for (int k = 0; k < NUM; k++) tbl[0].rows[k] = W'(k + 1);
        tbl[0].cols = {8'h00, 8'h00, 8'h80, 8'h78, 8'h66, 8'h55};
        tbl[0].nrows = 8'(NUM); tbl[0].bp = 2'd0; tbl[0].gap = 1'b0; tbl[0].lof = 1'b1; tbl[0].err = 1'b0;
        tbl[1].rows = '0;
        for (int k = 0; k < 3; k++) tbl[1].rows[k] = 6'h3F;
        tbl[1].cols = {6{8'h07}};
        tbl[1].nrows = 8'd3; tbl[1].bp = 2'd0; tbl[1].gap = 1'b0; tbl[1].lof = 1'b0; tbl[1].err = 1'b1;
        tbl[2] = tbl[0]; tbl[2].bp = 2'd1; tbl[2].lof = 1'b0;
        tbl[3] = tbl[0]; tbl[3].gap = 1'b1;
        for (int k = 0; k < NUM; k++) tbl[4].rows[k] = 6'h01;
        tbl[4].cols = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        tbl[4].nrows = 8'(NUM); tbl[4].bp = 2'd0; tbl[4].gap = 1'b0; tbl[4].lof = 1'b0; tbl[4].err = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_err_short", err_short, 1'b0);
        chk("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        @(negedge clock);
        chk("rst_release_ready", in_ready, 1'b1);

        // Directed table, blocks offered back to back
        for (int i = 0; i < 5; i++) begin
            run_block(tbl[i].rows, int'(tbl[i].nrows), int'(tbl[i].bp), int'(tbl[i].gap), int'(tbl[i].lof), W);
            check_block($sformatf("vec%0d", i), tbl[i].cols, int'(tbl[i].err), int'(tbl[i].bp));
        end

        // Reset mid-FILL discards partial rows silently
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_data = 6'h2A; in_last = 1'b0; out_ready = 1'b1;
        end
        @(negedge clock);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clock);
        chk("fill_rst_err", err_short, 1'b0);
        chk("fill_rst_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clock);
        chk("fill_rst_ready", in_ready, 1'b1);
        run_block(tbl[0].rows, NUM, 0, 0, 0, W);
        check_block("after_fill_rst", tbl[0].cols, 0, 0);

        // Reset mid-DRAIN after column 2
        run_block(tbl[0].rows, NUM, 0, 0, 0, 3);
        @(negedge clock);
        out_ready = 1'b0; rst_n = 1'b0;
        @(negedge clock);
        chk("drain_rst_valid", out_valid, 1'b0);
        chk("drain_rst_last", out_last, 1'b0);
        chk("drain_rst_data", out_data, '0);
        chk("drain_rst_err", err_short, 1'b0);
        rst_n = 1'b1;
        @(negedge clock);
        chk("drain_rst_ready", in_ready, 1'b1);
        run_block(tbl[1].rows, 3, 0, 0, 0, W);
        check_block("after_drain_rst", tbl[1].cols, 1, 0);

        // Randomized blocks against the reference model
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < NUM; k++) rr[k] = W'($urandom);
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NUM - 1)) : NUM;
            run_block(rr, n, ($urandom_range(0, 1) == 0) ? 0 : 2, int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), W);
            check_block($sformatf("rand%0d", i), model(rr, n), (n < NUM) ? 1 : 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
